image_three2four_pack: RTL and testbench

Converts a byte-serial 3-channel image stream (R, G, B bytes in order) into one 32-bit word per pixel, with the fourth byte filled with a constant pad. It is the counterpart to the image path's four-to-three channel stage: it restores 4-byte pixel alignment before data is written back to the 32-bit frame buffer or DMA. A start/done handshake frames each transfer with a programmed pixel count.

---
 rtl/image_three2four_pack.sv | 105 ++++++++++
 tb/tb_image_three2four_pack.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_three2four_pack.sv
// image_three2four_pack: packs a byte-serial R,G,B stream into one 32-bit
// word per pixel, {PAD_BYTE, B, G, R}, framed by a start/done handshake.
module image_three2four_pack #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_BITS-1:0] pixel_total,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [31:0]         m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nx;
  logic [1:0]          idx;
  logic [7:0]          stg_r, stg_g;
  logic [CNT_BITS-1:0] cnt, total, cnt_inc;
  logic                s_acc, byte2_acc, m_hs, last_pix;

  assign s_acc     = s_valid && s_ready;
  assign byte2_acc = s_acc && (idx == 2'd2);
  assign m_hs      = m_valid && m_ready;
  assign cnt_inc   = cnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
  assign last_pix  = (cnt_inc == total);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  // Input is open in RUN; the third byte waits until the output register is free.
  always_comb begin
    s_ready = 1'b0;
    if (state == RUN)
      s_ready = (idx == 2'd2) ? (!m_valid || m_ready) : 1'b1;
  end

  // Next-state logic. A zero-pixel transfer passes through DRAIN, which exits
  // at once with an empty output register; that gives the one busy cycle
  // before done.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (pixel_total == '0) ? DRAIN : RUN;
      RUN:   if (byte2_acc && last_pix) state_nx = DRAIN;
      DRAIN: if (!m_valid || m_ready) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Transfer bookkeeping: total latch, byte index and pixel count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total <= '0;
      cnt   <= '0;
      idx   <= 2'd0;
    end else if (state == IDLE && start) begin
      total <= pixel_total;
      cnt   <= '0;
      idx   <= 2'd0;
    end else if (s_acc) begin
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (idx == 2'd2) cnt <= cnt_inc;
    end
  end

  // Staging for R and G, kept apart from m_data so a stalled word never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_r <= 8'h00;
      stg_g <= 8'h00;
    end else if (s_acc) begin
      if (idx == 2'd0) stg_r <= s_data;
      if (idx == 2'd1) stg_g <= s_data;
    end
  end

  // Output register: loaded on the third byte, freed by the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= 32'h0;
      m_valid <= 1'b0;
    end else if (byte2_acc) begin
      m_data  <= {PAD_BYTE, s_data, stg_g, stg_r};
      m_valid <= 1'b1;
    end else if (m_hs) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_three2four_pack.sv
// Bench for image_three2four_pack: two instances (pad 00 and pad FF) share
// the same stimulus; expected words come from grouping sent bytes in threes.
module tb_image_three2four_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pixel_total = 16'd0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic        s_ready0, s_ready1, m_valid0, m_valid1, busy0, busy1, done0, done1;
  logic [31:0] m_data0, m_data1;

  image_three2four_pack #(.PAD_BYTE(8'h00), .CNT_BITS(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pixel_total(pixel_total),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready),
    .busy(busy0), .done(done0));

  image_three2four_pack #(.PAD_BYTE(8'hFF), .CNT_BITS(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pixel_total(pixel_total),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
    .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  int          errors = 0, checks = 0, cyc = 0;
  int          hs_cnt = 0, mv_cnt = 0, last_hs = 0;
  bit          mr_rand = 1'b0;
  logic [31:0] q0[$], q1[$];
  logic [7:0]  txq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Random downstream back-pressure when enabled.
  always @(negedge clk) if (mr_rand) m_ready = ($urandom_range(0, 3) != 0);

  // Monitor: pops the scoreboard on every output handshake.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      if (m_valid0) mv_cnt++;
      if (m_valid0 && m_ready) begin
        hs_cnt++;
        last_hs = cyc;
        if (q0.size() == 0) chk("unexpected_word_pad00", m_data0, 32'hxxxxxxxx);
        else chk("word_pad00", m_data0, q0.pop_front());
      end
      if (m_valid1 && m_ready) begin
        if (q1.size() == 0) chk("unexpected_word_padff", m_data1, 32'hxxxxxxxx);
        else chk("word_padff", m_data1, q1.pop_front());
      end
    end
  end

  // Golden packing: every three bytes in order form {pad, b2, b1, b0}.
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back({8'h00, txq[3*i+2], txq[3*i+1], txq[3*i]});
      q1.push_back({8'hFF, txq[3*i+2], txq[3*i+1], txq[3*i]});
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    pixel_total = 16'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends every byte of txq, holding each until accepted.
  task automatic send_all(input bit gaps);
    int t;
    for (int i = 0; i < txq.size(); i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data = 8'($urandom);
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data = txq[i];
      t = 0;
      forever begin
        #4;
        if (s_ready0) begin @(posedge clk); break; end
        if (++t > 2000) begin
          chk("send_timeout", 32'd0, 32'd1);
          s_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #4;
      if (done0) begin dc = cyc; break; end
    end
    chk("done_seen", 32'(dc != -1), 32'd1);
  endtask

  initial begin
    int dc;
    // Reset state
    #12;
    chk("rst_s_ready", {s_ready0, s_ready1}, 2'b00);
    chk("rst_m_valid", {m_valid0, m_valid1}, 2'b00);
    chk("rst_m_data", m_data0 | m_data1, 32'h0);
    chk("rst_busy_done", {busy0, busy1, done0, done1}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two pixels at full rate
    m_ready = 1'b1;
    txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    push_words(2);
    mv_cnt = 0;
    do_start(2);
    #4 chk("busy_after_start", busy0, 1'b1);
    send_all(1'b0);
    wait_done(50, dc);
    chk("done_latency", 32'(dc), 32'(last_hs + 1));
    chk("busy_low_at_done", busy0, 1'b0);
    chk("mvalid_cycles", 32'(mv_cnt), 32'd2);
    @(negedge clk) #4 chk("done_one_cycle", done0, 1'b0);

    // Output stall holds the word and blocks the third byte
    m_ready = 1'b0;
    txq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    push_words(3);
    do_start(3);
    fork
      send_all(1'b0);
      begin
        for (int i = 0; i < 20 && !m_valid0; i++) @(negedge clk) #4;
        chk("stall_mvalid", m_valid0, 1'b1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk) #4;
          chk("stall_mdata", m_data0, 32'h00030201);
          chk("stall_mdata_ff", m_data1, 32'hFF030201);
          if (i >= 2) chk("stall_s_ready", s_ready0, 1'b0);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #4 chk("byte06_accepted", {s_ready0, s_valid, s_data}, {2'b11, 8'h06});
      end
    join
    wait_done(50, dc);

    // Single pixel, pad 00 and FF instances
    txq = '{8'hAA, 8'hBB, 8'hCC};
    push_words(1);
    do_start(1);
    send_all(1'b0);
    wait_done(50, dc);
    @(negedge clk) #4 chk("idle_after_done", {busy0, done0, busy1, done1}, 4'h0);

    // Zero-pixel transfer
    mv_cnt = 0;
    s_valid = 1'b1;
    do_start(0);
    #4 chk("zero_cycle1", {busy0, done0, s_ready0}, 3'b100);
    @(negedge clk) #4 chk("zero_cycle2", {busy0, done0, s_ready0}, 3'b010);
    @(negedge clk) #4 chk("zero_cycle3", {busy0, done0}, 2'b00);
    chk("zero_no_mvalid", 32'(mv_cnt), 32'd0);
    s_valid = 1'b0;

    // 100 random pixels, random gaps, stray start mid-transfer
    txq.delete();
    for (int i = 0; i < 300; i++) txq.push_back(8'($urandom));
    push_words(100);
    hs_cnt = 0;
    do_start(100);
    mr_rand = 1'b1;
    fork
      send_all(1'b1);
      begin
        repeat (40) @(negedge clk);
        start = 1'b1;
        pixel_total = 16'd5;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_done(3000, dc);
    mr_rand = 1'b0;
    m_ready = 1'b1;
    chk("random_word_count", 32'(hs_cnt), 32'd100);
    chk("random_queue_empty", 32'(q0.size() + q1.size()), 32'd0);

    // Reset mid-transfer with a pending word and a partly staged pixel
    m_ready = 1'b0;
    txq = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h22};
    do_start(2);
    send_all(1'b0);
    #4 chk("pending_before_rst", m_valid0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_outputs", {m_valid0, s_ready0, busy0, done0, m_valid1}, 5'h0);
    chk("rst_mid_mdata", m_data0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    txq = '{8'h33, 8'h44, 8'h55};
    push_words(1);
    do_start(1);
    send_all(1'b0);
    wait_done(50, dc);
    chk("final_queue_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
